// File: rtl/seq_to_checker.sv
// rtl/seq_to_checker.sv - golden-model response checker for Sequential_TO
// Optional mismatch capture outputs enabled by defining SEQ_TO_CHK_CAPTURE_EN.
module seq_to_checker #(
    parameter int XW           = 6,
    parameter int SW           = 4,
    parameter int CW           = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dut_reset,
    input  logic          load,
    input  logic [SW-1:0] S,
    input  logic [XW-1:0] X,
    input  logic [XW-1:0] Z,
    input  logic          clear,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [CW-1:0] check_count,
    output logic [CW-1:0] err_count,
    output logic [SW-1:0] model_state
`ifdef SEQ_TO_CHK_CAPTURE_EN
    ,
    output logic          cap_valid,
    output logic [XW-1:0] cap_X,
    output logic [SW-1:0] cap_S,
    output logic [SW-1:0] cap_state,
    output logic [XW-1:0] cap_z_exp,
    output logic [XW-1:0] cap_z_obs,
    output logic [CW-1:0] cap_cycle
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } fsm_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    fsm_t          r_fsm;
    fsm_t          w_fsm_next;
    logic [SW-1:0] r_state;
    logic [CW-1:0] r_chk_cnt;
    logic [CW-1:0] r_err_cnt;
    logic          r_fail;
    logic          r_pass;
    logic          r_busy;

    logic [XW-1:0] w_state_ext;
    logic [XW-1:0] w_z_exp;
    logic          w_frozen;
    logic          w_do_cmp;
    logic          w_mismatch;
    logic [CW-1:0] w_chk_next;
    logic [CW-1:0] w_err_next;

    // Upper state bits that do not fit after the x4 shift simply fall off.
    assign w_state_ext = XW'(r_state);
    assign w_z_exp     = (w_state_ext << 2) + X;

    assign w_frozen   = (STOP_ON_FAIL != 0) && (r_fsm == ST_FAIL);
    assign w_do_cmp   = (r_fsm == ST_CHECK) && en && !dut_reset && !clear;
    assign w_mismatch = w_do_cmp && (Z != w_z_exp);

    always_comb begin
        w_chk_next = r_chk_cnt;
        w_err_next = r_err_cnt;
        if (clear) begin
            w_chk_next = '0;
            w_err_next = '0;
        end else if (w_do_cmp) begin
            if (r_chk_cnt != CNT_MAX) begin
                w_chk_next = r_chk_cnt + 1'b1;
            end
            if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
                w_err_next = r_err_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE: begin
                if (en) begin
                    w_fsm_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    w_fsm_next = ST_IDLE;
                end else if (dut_reset || load) begin
                    w_fsm_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!en) begin
                    w_fsm_next = ST_IDLE;
                end else if (w_mismatch && (STOP_ON_FAIL != 0)) begin
                    w_fsm_next = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (clear) begin
                    w_fsm_next = ST_ARMED;
                end
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm     <= ST_IDLE;
            r_state   <= '0;
            r_chk_cnt <= '0;
            r_err_cnt <= '0;
            r_fail    <= 1'b0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_next;
            r_busy    <= (w_fsm_next == ST_CHECK);
            r_chk_cnt <= w_chk_next;
            r_err_cnt <= w_err_next;
            r_pass    <= (w_chk_next != '0) && (w_err_next == '0);
            if (clear) begin
                r_fail <= 1'b0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
            end
            // dut_reset outranks load, mirroring the DUT's own priority.
            if (!w_frozen) begin
                if (dut_reset) begin
                    r_state <= '0;
                end else if (load) begin
                    r_state <= S;
                end else begin
                    r_state <= r_state + 1'b1;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign check_count = r_chk_cnt;
    assign err_count   = r_err_cnt;
    assign model_state = r_state;

`ifdef SEQ_TO_CHK_CAPTURE_EN
    logic          r_cap_valid;
    logic [XW-1:0] r_cap_x;
    logic [SW-1:0] r_cap_s;
    logic [SW-1:0] r_cap_state;
    logic [XW-1:0] r_cap_z_exp;
    logic [XW-1:0] r_cap_z_obs;
    logic [CW-1:0] r_cap_cycle;

    // Only the first mismatch since reset/clear is kept; cap_cycle is its ordinal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_valid <= 1'b0;
            r_cap_x     <= '0;
            r_cap_s     <= '0;
            r_cap_state <= '0;
            r_cap_z_exp <= '0;
            r_cap_z_obs <= '0;
            r_cap_cycle <= '0;
        end else if (clear) begin
            r_cap_valid <= 1'b0;
            r_cap_x     <= '0;
            r_cap_s     <= '0;
            r_cap_state <= '0;
            r_cap_z_exp <= '0;
            r_cap_z_obs <= '0;
            r_cap_cycle <= '0;
        end else if (w_mismatch && !r_cap_valid) begin
            r_cap_valid <= 1'b1;
            r_cap_x     <= X;
            r_cap_s     <= S;
            r_cap_state <= r_state;
            r_cap_z_exp <= w_z_exp;
            r_cap_z_obs <= Z;
            r_cap_cycle <= w_chk_next;
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_X     = r_cap_x;
    assign cap_S     = r_cap_s;
    assign cap_state = r_cap_state;
    assign cap_z_exp = r_cap_z_exp;
    assign cap_z_obs = r_cap_z_obs;
    assign cap_cycle = r_cap_cycle;
`endif

endmodule

// File: tb/tb_seq_to_checker.sv
// tb/tb_seq_to_checker.sv - directed self-checking bench for seq_to_checker
module tb_seq_to_checker;

    logic        clk;
    logic        reset;
    logic        en;
    logic        dut_reset;
    logic        load;
    logic [3:0]  S;
    logic [5:0]  X;
    logic [5:0]  Z;
    logic        clear;

    logic        busy, pass, fail;
    logic [15:0] check_count, err_count;
    logic [3:0]  model_state;

    logic        s_busy, s_pass, s_fail;
    logic [15:0] s_check_count, s_err_count;
    logic [3:0]  s_model_state;

`ifdef SEQ_TO_CHK_CAPTURE_EN
    logic        cap_valid, s_cap_valid;
    logic [5:0]  cap_X, s_cap_X;
    logic [3:0]  cap_S, s_cap_S;
    logic [3:0]  cap_state, s_cap_state;
    logic [5:0]  cap_z_exp, s_cap_z_exp;
    logic [5:0]  cap_z_obs, s_cap_z_obs;
    logic [15:0] cap_cycle, s_cap_cycle;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_to_checker #(.XW(6), .SW(4), .CW(16), .STOP_ON_FAIL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .dut_reset(dut_reset), .load(load),
        .S(S), .X(X), .Z(Z), .clear(clear),
        .busy(busy), .pass(pass), .fail(fail),
        .check_count(check_count), .err_count(err_count), .model_state(model_state)
`ifdef SEQ_TO_CHK_CAPTURE_EN
        , .cap_valid(cap_valid), .cap_X(cap_X), .cap_S(cap_S), .cap_state(cap_state),
        .cap_z_exp(cap_z_exp), .cap_z_obs(cap_z_obs), .cap_cycle(cap_cycle)
`endif
    );

    seq_to_checker #(.XW(6), .SW(4), .CW(16), .STOP_ON_FAIL(1)) dut_stop (
        .clk(clk), .reset(reset), .en(en), .dut_reset(dut_reset), .load(load),
        .S(S), .X(X), .Z(Z), .clear(clear),
        .busy(s_busy), .pass(s_pass), .fail(s_fail),
        .check_count(s_check_count), .err_count(s_err_count), .model_state(s_model_state)
`ifdef SEQ_TO_CHK_CAPTURE_EN
        , .cap_valid(s_cap_valid), .cap_X(s_cap_X), .cap_S(s_cap_S), .cap_state(s_cap_state),
        .cap_z_exp(s_cap_z_exp), .cap_z_obs(s_cap_z_obs), .cap_cycle(s_cap_cycle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; dut_reset = 1'b0; load = 1'b0;
        S = '0; X = '0; Z = '0; clear = 1'b0;
        #3;
        check("rst_busy",  busy, 0);
        check("rst_pass",  pass, 0);
        check("rst_fail",  fail, 0);
        check("rst_chk",   check_count, 0);
        check("rst_err",   err_count, 0);
        check("rst_state", model_state, 0);
        #9;
        reset = 1'b1;
        en    = 1'b1;
        tick();
        dut_reset = 1'b1;
        tick();
        check("sync_busy",  busy, 1);
        check("sync_state", model_state, 0);
        check("sync_chk",   check_count, 0);
        dut_reset = 1'b0;

        // Correct DUT: at step i the state is i-1, so Z = 4*(i-1)+i.
        for (int i = 1; i <= 11; i++) begin
            X = 6'(i);
            Z = 6'(5 * i - 4);
            tick();
        end
        check("run_chk",   check_count, 11);
        check("run_err",   err_count, 0);
        check("run_pass",  pass, 1);
        check("run_fail",  fail, 0);
        check("run_state", model_state, 11);

        load = 1'b1; S = 4'hE; X = 6'd0; Z = 6'd44;
        tick();
        check("load_state", model_state, 4'hE);
        load = 1'b0; X = 6'd3; Z = 6'd59;
        tick();
        check("wrap_f", model_state, 4'hF);
        Z = 6'd63;
        tick();
        check("wrap_0", model_state, 4'h0);
        Z = 6'd3;
        tick();
        check("wrap_1",   model_state, 4'h1);
        check("wrap_chk", check_count, 15);
        check("wrap_err", err_count, 0);

        X = 6'd5; Z = 6'd0;
        tick();
        check("bad_err",  err_count, 1);
        check("bad_fail", fail, 1);
        check("bad_pass", pass, 0);
        check("bad_chk",  check_count, 16);
`ifdef SEQ_TO_CHK_CAPTURE_EN
        check("cap_valid", cap_valid, 1);
        check("cap_zexp",  cap_z_exp, 9);
        check("cap_zobs",  cap_z_obs, 0);
        check("cap_state", cap_state, 1);
        check("cap_x",     cap_X, 5);
        check("cap_cycle", cap_cycle, 16);
`endif
        X = 6'd0; Z = 6'd8;
        tick();
        check("sticky_fail", fail, 1);
        check("sticky_err",  err_count, 1);
        check("stop_frz_state", s_model_state, 2);
        check("stop_frz_chk",   s_check_count, 16);
        check("stop_frz_busy",  s_busy, 0);

        clear = 1'b1; Z = 6'd0;
        tick();
        clear = 1'b0;
        check("clr_chk",  check_count, 0);
        check("clr_err",  err_count, 0);
        check("clr_fail", fail, 0);
        check("clr_stop_err",  s_err_count, 0);
        check("clr_stop_fail", s_fail, 0);
        check("clr_stop_busy", s_busy, 0);
`ifdef SEQ_TO_CHK_CAPTURE_EN
        check("clr_cap_valid", cap_valid, 0);
        check("clr_cap_zexp",  cap_z_exp, 0);
`endif
        load = 1'b1; S = 4'd5; X = 6'd0; Z = 6'd16;
        tick();
        load = 1'b0;
        check("arm_stop_busy",  s_busy, 1);
        check("arm_stop_state", s_model_state, 5);
        check("arm_chk",        check_count, 1);

        Z = 6'd1;
        tick();
        tick();
        check("stop_err",   s_err_count, 1);
        check("stop_chk",   s_check_count, 1);
        check("stop_busy",  s_busy, 0);
        check("stop_state", s_model_state, 6);
        check("stop_fail",  s_fail, 1);
        check("main_err2",  err_count, 2);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("stop_clr_err",  s_err_count, 0);
        check("stop_clr_fail", s_fail, 0);
        load = 1'b1; S = 4'd2; X = 6'd0; Z = 6'd32;
        tick();
        check("resume_busy", s_busy, 1);
        load = 1'b0; X = 6'd1; Z = 6'd9;
        tick();
        check("resume_chk",  s_check_count, 1);
        check("resume_pass", s_pass, 1);
        check("resume_main", check_count, 2);

        dut_reset = 1'b1; load = 1'b1; S = 4'd9; Z = 6'h2A;
        tick();
        dut_reset = 1'b0; load = 1'b0;
        check("rl_chk",   check_count, 2);
        check("rl_err",   err_count, 0);
        check("rl_state", model_state, 0);
        check("rl_stop_state", s_model_state, 0);

        X = 6'd0; Z = 6'd0;
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy",  busy, 0);
        check("arst_chk",   check_count, 0);
        check("arst_pass",  pass, 0);
        check("arst_state", model_state, 0);
        en = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("post_busy", busy, 0);
        check("post_chk",  check_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
